// File: rtl/cv32e40s_lockstep_pkg.sv
// Shared types and default constants for the lockstep comparator and its fault controller.
package cv32e40s_lockstep_pkg;

  typedef enum logic [1:0] {
    LS_IDLE    = 2'd0,
    LS_MONITOR = 2'd1,
    LS_FAULT   = 2'd2,
    LS_RECOVER = 2'd3
  } lockstep_state_e;

  localparam int          LOCKSTEP_THRESHOLD_DEFAULT = 2;
  localparam int unsigned LOCKSTEP_CNT_W_DEFAULT     = 8;

endpackage

// File: rtl/cv32e40s_lockstep_fault_ctrl_if.sv
// Signal bundle between the lockstep fault controller and its surroundings.
interface cv32e40s_lockstep_fault_ctrl_if
  import cv32e40s_lockstep_pkg::*;
#(
  parameter int unsigned CNT_W = LOCKSTEP_CNT_W_DEFAULT
);
  logic             enable_i;
  logic             error_i;
  logic             clear_i;
  logic             recover_ack_i;
  logic             minor_alert_o;
  logic             major_alert_o;
  logic             recover_req_o;
  logic             fault_sticky_o;
  logic [CNT_W-1:0] err_count_o;
  logic [1:0]       state_o;

  // Recovery handshake: recover_req_o rises after FAULT and stays high until
  // recover_ack_i is sampled high on a rising edge; req drops the next cycle.
  // recover_ack_i is ignored whenever recover_req_o is low.
  modport master (
    output enable_i, error_i, clear_i, recover_ack_i,
    input  minor_alert_o, major_alert_o, recover_req_o, fault_sticky_o,
           err_count_o, state_o
  );

  modport slave (
    input  enable_i, error_i, clear_i, recover_ack_i,
    output minor_alert_o, major_alert_o, recover_req_o, fault_sticky_o,
           err_count_o, state_o
  );
endinterface

// File: rtl/cv32e40s_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module cv32e40s_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/cv32e40s_lockstep_fault_ctrl.sv
// Filters lockstep mismatches, escalates persistent runs to a fault and drives
// the recovery request/acknowledge handshake.
module cv32e40s_lockstep_fault_ctrl
  import cv32e40s_lockstep_pkg::*;
#(
  parameter int          MISMATCH_THRESHOLD = LOCKSTEP_THRESHOLD_DEFAULT,
  parameter int unsigned CNT_W              = LOCKSTEP_CNT_W_DEFAULT
) (
  input logic                           clk_i,
  input logic                           rst_ni,
  cv32e40s_lockstep_fault_ctrl_if.slave bus
);
  localparam int unsigned      RUN_W    = $clog2(MISMATCH_THRESHOLD + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MISMATCH_THRESHOLD - 1);

  if (MISMATCH_THRESHOLD < 1) begin : g_bad_threshold
    $error("MISMATCH_THRESHOLD must be at least 1");
  end

  lockstep_state_e  state_q;
  logic [RUN_W-1:0] run_q;
  logic             minor_q;
  logic             major_q;
  logic             req_q;
  logic             sticky_q;
  logic             count_en;
  logic             fault_set;

  // Only mismatches seen while actively monitoring are counted.
  assign count_en  = (state_q == LS_MONITOR) && bus.enable_i && bus.error_i;
  assign fault_set = count_en && (run_q == RUN_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LS_IDLE;
      run_q   <= '0;
      minor_q <= 1'b0;
      major_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      minor_q <= count_en;
      case (state_q)
        LS_IDLE: begin
          if (bus.enable_i) state_q <= LS_MONITOR;
        end
        LS_MONITOR: begin
          if (!bus.enable_i) begin
            state_q <= LS_IDLE;
            run_q   <= '0;
          end else if (bus.error_i) begin
            if (fault_set) begin
              state_q <= LS_FAULT;
              run_q   <= '0;
              major_q <= 1'b1;
            end else begin
              run_q <= run_q + 1'b1;
            end
          end else begin
            run_q <= '0;
          end
        end
        LS_FAULT: begin
          state_q <= LS_RECOVER;
          major_q <= 1'b1;
          req_q   <= 1'b1;
        end
        LS_RECOVER: begin
          if (bus.recover_ack_i) begin
            state_q <= bus.enable_i ? LS_MONITOR : LS_IDLE;
            major_q <= 1'b0;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= LS_IDLE;
          run_q   <= '0;
          major_q <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // A fault entry on the same edge as a software clear keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
    end else if (fault_set) begin
      sticky_q <= 1'b1;
    end else if (bus.clear_i) begin
      sticky_q <= 1'b0;
    end
  end

  cv32e40s_sat_counter #(
    .W (CNT_W)
  ) u_err_count (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (count_en),
    .clr    (bus.clear_i),
    .count  (bus.err_count_o)
  );

  assign bus.minor_alert_o  = minor_q;
  assign bus.major_alert_o  = major_q;
  assign bus.recover_req_o  = req_q;
  assign bus.fault_sticky_o = sticky_q;
  assign bus.state_o        = state_q;
endmodule

// File: tb/tb_cv32e40s_lockstep_fault_ctrl.sv
// Directed bench for the lockstep fault controller: two instances (8-bit and
// 2-bit counters) share stimulus and are compared each cycle against a model.
module tb_cv32e40s_lockstep_fault_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, err = 1'b0, clr = 1'b0, ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cv32e40s_lockstep_fault_ctrl_if #(.CNT_W(8)) ifa ();
  cv32e40s_lockstep_fault_ctrl_if #(.CNT_W(2)) ifb ();

  assign ifa.enable_i = en;  assign ifa.error_i = err;
  assign ifa.clear_i  = clr; assign ifa.recover_ack_i = ack;
  assign ifb.enable_i = en;  assign ifb.error_i = err;
  assign ifb.clear_i  = clr; assign ifb.recover_ack_i = ack;

  cv32e40s_lockstep_fault_ctrl #(.MISMATCH_THRESHOLD(2), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
  cv32e40s_lockstep_fault_ctrl #(.MISMATCH_THRESHOLD(2), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

  // ---------------- behavioural model ----------------
  typedef struct {
    int mode;    // 0 idle, 1 monitor, 2 fault, 3 recover
    int streak;  // consecutive mismatches seen in the current run
    int cnt;
    bit sticky;
    bit minor;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.streak = 0; r.cnt = 0; r.sticky = 0; r.minor = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int thr, int maxc,
                                    bit e, bit x, bit c, bit a);
    mdl_t n = s;
    bit counted = (s.mode == 1) && e && x;
    bit faults  = counted && (s.streak + 1 >= thr);
    n.minor = counted;
    if (counted) n.cnt = (s.cnt + 1 > maxc) ? maxc : s.cnt + 1;
    if (c) n.cnt = 0;
    if (faults) n.sticky = 1;
    else if (c) n.sticky = 0;
    if (s.mode == 0) begin
      if (e) n.mode = 1;
    end else if (s.mode == 1) begin
      n.streak = counted ? s.streak + 1 : 0;
      if (!e) n.mode = 0;
      else if (faults) begin n.mode = 2; n.streak = 0; end
    end else if (s.mode == 2) begin
      n.mode = 3;
    end else if (a) begin
      n.mode = e ? 1 : 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, 2, 255, en, err, clr, ack);
      mb = mdl_step(mb, 2, 3, en, err, clr, ack);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle scoreboard compare, away from the rising edge.
  always @(negedge clk) begin
    check("a_state",  int'(ifa.state_o),        ma.mode);
    check("a_major",  int'(ifa.major_alert_o),  int'(ma.mode >= 2));
    check("a_req",    int'(ifa.recover_req_o),  int'(ma.mode == 3));
    check("a_minor",  int'(ifa.minor_alert_o),  int'(ma.minor));
    check("a_sticky", int'(ifa.fault_sticky_o), int'(ma.sticky));
    check("a_cnt",    int'(ifa.err_count_o),    ma.cnt);
    check("b_state",  int'(ifb.state_o),        mb.mode);
    check("b_cnt",    int'(ifb.err_count_o),    mb.cnt);
    check("b_sticky", int'(ifb.fault_sticky_o), int'(mb.sticky));
  end

  // Apply inputs now (at a falling edge); return after the next rising edge
  // has sampled them, at the following falling edge.
  task automatic step(input bit e, input bit x, input bit c, input bit a);
    en = e; err = x; clr = c; ack = a;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_state",  int'(ifa.state_o), 0);
    check("rst_cnt",    int'(ifa.err_count_o), 0);
    check("rst_sticky", int'(ifa.fault_sticky_o), 0);
    check("rst_major",  int'(ifa.major_alert_o), 0);
    check("rst_req",    int'(ifa.recover_req_o), 0);
    rst_n = 1'b1;

    step(1, 0, 0, 0);
    check("en_monitor", int'(ifa.state_o), 1);

    // Isolated mismatches never fault.
    step(1, 1, 0, 0); check("iso1_minor", int'(ifa.minor_alert_o), 1);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("iso3_cnt",   int'(ifa.err_count_o), 3);
    check("iso3_state", int'(ifa.state_o), 1);
    check("iso3_major", int'(ifa.major_alert_o), 0);
    step(1, 0, 0, 0); check("iso_minor_low", int'(ifa.minor_alert_o), 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("cnt_a5",  int'(ifa.err_count_o), 5);
    check("sat_b3",  int'(ifb.err_count_o), 3);
    step(1, 0, 0, 0);

    // Clear coincident with a counted mismatch.
    step(1, 1, 1, 0);
    check("clr_win_a", int'(ifa.err_count_o), 0);
    check("clr_win_b", int'(ifb.err_count_o), 0);
    check("clr_minor", int'(ifa.minor_alert_o), 1);

    // Two consecutive mismatches; clear on the fault-entry edge.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0); check("run1_state", int'(ifa.state_o), 1);
    step(1, 1, 1, 0);
    check("fault_state",  int'(ifa.state_o), 2);
    check("fault_major",  int'(ifa.major_alert_o), 1);
    check("fault_sticky", int'(ifa.fault_sticky_o), 1);
    check("fault_req",    int'(ifa.recover_req_o), 0);
    check("fault_cnt",    int'(ifa.err_count_o), 0);
    step(1, 1, 0, 0);
    check("rec_state", int'(ifa.state_o), 3);
    check("rec_req",   int'(ifa.recover_req_o), 1);
    repeat (3) step(1, 1, 0, 0);
    check("rec_nocount", int'(ifa.err_count_o), 0);
    step(1, 0, 0, 1);
    check("ack_monitor", int'(ifa.state_o), 1);
    check("ack_req",     int'(ifa.recover_req_o), 0);
    check("ack_major",   int'(ifa.major_alert_o), 0);
    check("ack_sticky",  int'(ifa.fault_sticky_o), 1);

    // Second fault; enable dropped during recovery.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0); check("f2_state", int'(ifa.state_o), 2);
    step(0, 0, 0, 0); check("f2_rec", int'(ifa.state_o), 3);
    step(0, 0, 0, 0); check("f2_hold", int'(ifa.state_o), 3);
    step(0, 0, 0, 1);
    check("f2_idle",   int'(ifa.state_o), 0);
    check("f2_sticky", int'(ifa.fault_sticky_o), 1);
    step(0, 0, 0, 1); check("stray_ack", int'(ifa.state_o), 0);
    step(0, 0, 1, 0);
    check("clr_sticky", int'(ifa.fault_sticky_o), 0);
    check("clr_cnt",    int'(ifa.err_count_o), 0);

    // Enable drop beats a mismatch and clears the run.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("drop_state", int'(ifa.state_o), 0);
    check("drop_cnt",   int'(ifa.err_count_o), 1);
    check("drop_minor", int'(ifa.minor_alert_o), 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("runclr_state", int'(ifa.state_o), 1);
    check("runclr_cnt",   int'(ifa.err_count_o), 2);

    // Asynchronous reset in the middle of a recovery handshake.
    step(1, 1, 0, 0); check("f3_state", int'(ifa.state_o), 2);
    step(1, 0, 0, 0); check("f3_req", int'(ifa.recover_req_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state",  int'(ifa.state_o), 0);
    check("arst_req",    int'(ifa.recover_req_o), 0);
    check("arst_major",  int'(ifa.major_alert_o), 0);
    check("arst_sticky", int'(ifa.fault_sticky_o), 0);
    check("arst_cnt",    int'(ifa.err_count_o), 0);
    en = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", int'(ifa.state_o), 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
